// File: rtl/chunked_addsub_seq_pkg.sv
// Shared types and helpers for chunked_addsub_seq.
// Optional build macro: ADDSUB_SAT_EN (saturating result on signed overflow).
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MAX_W = 64;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Largest positive two's-complement value of the given width (0111..1).
  function automatic logic [MAX_W-1:0] sat_pos(input int unsigned width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  // Most negative two's-complement value of the given width (1000..0).
  function automatic logic [MAX_W-1:0] sat_neg(input int unsigned width);
    return MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/chunked_addsub_seq_if.sv
// Start/done handshake and operand/result bus of chunked_addsub_seq.
interface chunked_addsub_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_addsub_seq_chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple of full adders; also exposes the carry
// into the chunk MSB so the caller can derive signed overflow.
module chunk_ripple_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  // One full adder per bit, carry rippling from bit 0 upwards.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per cycle with a registered
// carry between chunks. Optional macro ADDSUB_SAT_EN saturates sum on overflow.
module chunked_addsub_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  chunked_addsub_seq_if.slave  bus
);
  import addsub_pkg::*;

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout, ch_cmsb;

  // Operands are shifted right each cycle, so the active chunk always sits
  // in the low CHUNK bits; on the last chunk those bits hold the word MSBs.
  chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .cin   (carry_q),
    .sum   (ch_sum),
    .cout  (ch_cout),
    .c_msb (ch_cmsb)
  );

  // Next-state and datapath computation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        work_d  = WIDTH'({ch_sum, work_q} >> CHUNK);
        carry_d = ch_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          sum_d   = work_d;
          cout_d  = ch_cout;
          ovf_d   = ch_cmsb ^ ch_cout;
`ifdef ADDSUB_SAT_EN
          if (ch_cmsb ^ ch_cout) begin
            sum_d = a_q[CHUNK-1] ? SAT_NEG : SAT_POS;
          end
`endif
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_addsub_seq.sv
// Directed self-checking bench for chunked_addsub_seq at WIDTH=16 with
// CHUNK=4, CHUNK=1 and CHUNK=16. Honours ADDSUB_SAT_EN for expected sums.
module tb_chunked_addsub_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef ADDSUB_SAT_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_OVF = 16'h8000;
  localparam logic [15:0] EXP_NEG_OVF = 16'h7FFF;
`endif

  always #5 clk = ~clk;

  chunked_addsub_seq_if #(.WIDTH(16)) bus4 ();
  chunked_addsub_seq_if #(.WIDTH(16)) bus1 ();
  chunked_addsub_seq_if #(.WIDTH(16)) bus16 ();

  chunked_addsub_seq #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  chunked_addsub_seq #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  chunked_addsub_seq #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  // Output snapshot: {busy, done, cout, ovf, sum[15:0]}.
  function automatic logic [19:0] peek(input int unsigned w);
    case (w)
      1:       return {bus1.busy, bus1.done, bus1.cout, bus1.ovf, bus1.sum};
      16:      return {bus16.busy, bus16.done, bus16.cout, bus16.ovf, bus16.sum};
      default: return {bus4.busy, bus4.done, bus4.cout, bus4.ovf, bus4.sum};
    endcase
  endfunction

  task automatic drive(input int unsigned w, input logic st, input logic s,
                       input logic [15:0] x, input logic [15:0] y);
    case (w)
      1:       begin bus1.start = st;  bus1.sub = s;  bus1.a = x;  bus1.b = y;  end
      16:      begin bus16.start = st; bus16.sub = s; bus16.a = x; bus16.b = y; end
      default: begin bus4.start = st;  bus4.sub = s;  bus4.a = x;  bus4.b = y;  end
    endcase
  endtask

  // Issue one operation and observe it for up to 40 cycles.
  task automatic run_op(input int unsigned w, input logic s, input logic [15:0] x,
                        input logic [15:0] y, output int dc, output int bc,
                        output logic stable, output logic [15:0] r,
                        output logic co, output logic ov);
    logic [19:0] o;
    logic [15:0] prev;
    @(negedge clk);
    prev = peek(w) & 20'h0FFFF;
    drive(w, 1'b1, s, x, y);
    @(posedge clk);
    #1 drive(w, 1'b0, 1'b0, 16'h0, 16'h0);
    dc = -1; bc = 0; stable = 1'b1; r = 'x; co = 1'bx; ov = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      o = peek(w);
      if (o[19]) bc++;
      if (o[18]) begin
        dc = c; r = o[15:0]; co = o[17]; ov = o[16];
        break;
      end
      if (o[15:0] !== prev) stable = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [19:0] o;
    for (int unsigned w = 1; w <= 16; w++) begin
      if (w == 1 || w == 4 || w == 16) begin
        o = peek(w);
        n_checks++;
        if (o !== 20'h0) begin
          n_fail++;
          $display("FAIL reset_w%0d: got %h want %h", w, o, 20'h0);
        end
      end
    end
  endtask

  task automatic test_vectors4;
    logic        s_v [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] a_v [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] b_v [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic [15:0] r_v [5] = '{16'h1235, 16'h0000, EXP_POS_OVF, 16'hFFFE, EXP_NEG_OVF};
    logic        c_v [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        v_v [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int dc, bc;
    logic st, co, ov;
    logic [15:0] r;
    logic [34:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      run_op(4, s_v[i], a_v[i], b_v[i], dc, bc, st, r, co, ov);
      got = {8'(dc), 8'(bc), st, co, ov, r};
      exp = {8'd5, 8'd4, 1'b1, c_v[i], v_v[i], r_v[i]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL vec4_%0d {done_cyc,busy_cnt,stable,cout,ovf,sum}: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_ignored_start;
    logic [19:0] o;
    logic [15:0] prev, r;
    int dc, nd;
    logic st;
    logic [33:0] got, exp;
    @(negedge clk);
    prev = peek(4) & 20'h0FFFF;
    drive(4, 1'b1, 1'b0, 16'h1111, 16'h2222);
    @(posedge clk);
    #1 drive(4, 1'b0, 1'b0, 16'h1111, 16'h2222);
    dc = -1; nd = 0; st = 1'b1; r = 'x;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      o = peek(4);
      if (o[18]) begin
        nd++;
        if (dc < 0) begin dc = c; r = o[15:0]; end
      end
      if (c < 5 && o[15:0] !== prev) st = 1'b0;
      if (c == 2) drive(4, 1'b1, 1'b0, 16'hAAAA, 16'h1111);
      if (c == 3) drive(4, 1'b0, 1'b0, 16'h5555, 16'h0F0F);
    end
    got = {8'(dc), 8'(nd), 1'b0, st, r};
    exp = {8'd5, 8'd1, 1'b0, 1'b1, 16'h3333};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL ignored_start {done_cyc,n_done,stable,sum}: got %h want %h", got, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] o;
    int d1, d2;
    logic [15:0] r1, r2;
    logic b6, c2;
    logic [25:0] got_a, exp_a;
    logic [24:0] got_b, exp_b;
    @(negedge clk);
    drive(4, 1'b1, 1'b0, 16'h0010, 16'h0020);
    @(posedge clk);
    #1 drive(4, 1'b0, 1'b0, 16'h0, 16'h0);
    d1 = -1; d2 = -1; r1 = 'x; r2 = 'x; b6 = 1'bx; c2 = 1'bx;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      o = peek(4);
      if (o[18]) begin
        if (d1 < 0) begin d1 = c; r1 = o[15:0]; end
        else if (d2 < 0) begin d2 = c; r2 = o[15:0]; c2 = o[17]; end
      end
      if (c == 6) b6 = o[19];
      if (c == 5) drive(4, 1'b1, 1'b1, 16'h0100, 16'h0001);
      if (c == 6) drive(4, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    got_a = {8'(d1), 1'b0, 1'b0, r1};
    exp_a = {8'd5, 1'b0, 1'b0, 16'h0030};
    n_checks++;
    if (got_a !== exp_a) begin
      n_fail++;
      $display("FAIL b2b_first {done_cyc,sum}: got %h want %h", got_a, exp_a);
    end
    got_b = {8'(d2), b6, c2, 1'b0, r2[13:0]} ^ {9'b0, 2'b0, r2[15:14], 12'b0} & '0;
    got_b = {8'(d2), b6, r2};
    exp_b = {8'd10, 1'b1, 16'h00FF};
    n_checks++;
    if (got_b !== exp_b || c2 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second {done_cyc,busy_c6,sum} cout: got %h %b want %h 1", got_b, c2, exp_b);
    end
  endtask

  task automatic test_reset_mid;
    logic [19:0] o;
    int nd, dc, bc;
    logic st, co, ov;
    logic [15:0] r;
    logic [34:0] got, exp;
    @(negedge clk);
    drive(4, 1'b1, 1'b0, 16'h5555, 16'h1111);
    @(posedge clk);
    #1 drive(4, 1'b0, 1'b0, 16'h0, 16'h0);
    nd = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      o = peek(4);
      if (o[18]) nd++;
      if (c == 2) begin
        rst_n = 1'b0;
        #1 o = peek(4);
        n_checks++;
        if (o !== 20'h0) begin
          n_fail++;
          $display("FAIL reset_mid_outputs: got %h want %h", o, 20'h0);
        end
      end
      if (c == 3) rst_n = 1'b1;
    end
    n_checks++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got %0d want 0", nd);
    end
    run_op(4, 1'b0, 16'h0003, 16'h0004, dc, bc, st, r, co, ov);
    got = {8'(dc), 8'(bc), st, co, ov, r};
    exp = {8'd5, 8'd4, 1'b1, 1'b0, 1'b0, 16'h0007};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_fresh_op {done_cyc,busy_cnt,stable,cout,ovf,sum}: got %h want %h", got, exp);
    end
  endtask

  task automatic test_chunk_sizes;
    int unsigned w_v [2] = '{1, 16};
    int dc, bc;
    logic st, co, ov;
    logic [15:0] r;
    logic [34:0] got, exp;
    for (int i = 0; i < 2; i++) begin
      run_op(w_v[i], 1'b0, 16'h1234, 16'h0001, dc, bc, st, r, co, ov);
      got = {8'(dc), 8'(bc), st, co, ov, r};
      exp = {8'(16 / w_v[i] + 1), 8'(16 / w_v[i]), 1'b1, 1'b0, 1'b0, 16'h1235};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL chunk%0d_add {done_cyc,busy_cnt,stable,cout,ovf,sum}: got %h want %h", w_v[i], got, exp);
      end
      run_op(w_v[i], 1'b0, 16'hFFFF, 16'h0001, dc, bc, st, r, co, ov);
      got = {8'(dc), 8'(bc), st, co, ov, r};
      exp = {8'(16 / w_v[i] + 1), 8'(16 / w_v[i]), 1'b1, 1'b1, 1'b0, 16'h0000};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL chunk%0d_carry {done_cyc,busy_cnt,stable,cout,ovf,sum}: got %h want %h", w_v[i], got, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(4, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(16, 1'b0, 1'b0, 16'h0, 16'h0);
    #3;
    test_reset;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_vectors4;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid;
    test_chunk_sizes;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chunked_addsub_seq.md
Name: chunked_addsub_seq

Overview:
- Parametrised, multi-cycle successor to the fixed 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands by rippling CHUNK bits per clock through a chain of full adders.
- The carry is registered between chunks, so the combinational depth stays bounded for wide datapaths.
- Sits between operand registers and a consumer via a start/done handshake; also reports carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width. Legal: a multiple of CHUNK, and at least 2.
- CHUNK, 4, bits processed per RUN cycle. Legal: 1..WIDTH, must divide WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  0 = a+b, 1 = a-b; latched with the operands.
- a  in  WIDTH  operand A; latched on accepted start.
- b  in  WIDTH  operand B; latched on accepted start.
- busy  out  1  high while RUN.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  result register; holds until the next completion.
- cout  out  1  final carry. For sub, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, chunk index=0, carry=0. Reset asserted mid-operation aborts it; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge: latch a, latch b XOR {WIDTH{sub}}, set carry=sub, set idx=0, go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - chunk idx = a_chunk + b_chunk + carry.
  - Write the chunk result into the working register; carry <= chunk carry-out; idx++.
  - On idx = NCHUNK-1: transfer the full working result to sum; cout <= final carry; ovf <= (carry into MSB) XOR (carry out of MSB); go to DONE.
- DONE: lasts one cycle with done=1. Goes to IDLE, or straight back to RUN if start=1 (back-to-back allowed).
- Latency: start accepted at edge 0 → busy=1 for cycles 1..NCHUNK → done=1 in cycle NCHUNK+1, with sum/cout/ovf already updated in that cycle.
- start while busy=1 is ignored (not queued); a and b may change freely during RUN.
- sum/cout/ovf never show partial results; they change only at the completion edge.
- CHUNK=WIDTH: a single RUN cycle, done at cycle 2.
- Width wrap: the result is modulo 2^WIDTH unless saturation is enabled.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined:
  - On ovf=1, sum saturates: positive overflow (operand MSBs both 0 after inversion) → 0111..1; negative overflow → 1000..0.
  - ovf and cout are still reported unchanged.
- Undefined: sum wraps (plain modulo result).

Decomposition:
- Package addsub_pkg holds:
  - state typedef (IDLE/RUN/DONE);
  - function nchunk(WIDTH, CHUNK);
  - localparam-derived constants SAT_POS/SAT_NEG generator functions.
- Sub-module chunk_ripple_adder (combinational, parameter CHUNK):
  - a CHUNK-bit ripple of full-adder instances;
  - outputs the chunk sum, cout, and the carry into its MSB (needed for ovf).
- Top holds the FSM, index counter, carry register and operand/result registers.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- add 0x1234+0x0001, start cycle 0 → busy cycles 1-4; done cycle 5; sum=0x1235, cout=0, ovf=0.
- add 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0; proves the carry crosses all 4 chunk boundaries.
- add 0x7FFF+0x0001 → ovf=1, cout=0; sum=0x8000 (wrap) or 0x7FFF with ADDSUB_SAT_EN.
- sub 0x0005-0x0007 → sum=0xFFFE, cout=0, ovf=0.
- sub 0x8000-0x0001 → sum=0x7FFF, ovf=1, cout=1; with ADDSUB_SAT_EN, sum=0x8000.
- start pulse at cycle 2 during RUN → ignored; sum unchanged until cycle 5.
- start held during DONE cycle 5 → new op accepted, busy cycles 6-9, done cycle 10.
- rst_n low in cycle 2 → all outputs 0 immediately, no done; after release, a fresh 0x0003+0x0004 gives sum=0x0007 at done.
- Re-run the first two scenarios with CHUNK=1 (done cycle 17) and CHUNK=16 (done cycle 2).
